// File: rtl/dm_load_reader.sv
// dm_load_reader: read-side requester for the byte-enabled data memory.
// Accepts one load at a time from the MEM stage, issues a word read on the
// memory's synchronous read port, waits RD_LAT cycles, then extracts the
// addressed byte/halfword (little-endian) with sign or zero extension.
// Misaligned, out-of-range and illegal-op loads answer in one cycle with
// rsp_err = 1 and never strobe the memory.
//
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   req_valid/req_ready     request handshake; req_addr, req_op, req_pc payload
//   mem_rd_en, mem_addr     one-cycle read strobe and word index to memory
//   mem_rdata               read data, valid RD_LAT cycles after mem_rd_en
//   rsp_valid/rsp_ready     response handshake; rsp_data, rsp_err, rsp_pc payload
//
// Optional: define DM_LOAD_TRACE_EN to print a trace line on every response
// handshake (simulation only; no functional effect).
module dm_load_reader #(
  parameter int unsigned RD_LAT     = 1,             // 1..4
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
  parameter int unsigned AW         = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_pc,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic [31:0]   rsp_pc
);

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLhu = 3'b010;
  localparam logic [2:0] OpLb  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;

  localparam logic [1:0] CntLast = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    addr_lo_q;
  logic [2:0]    op_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   rsp_data_q;
  logic [31:0]   rsp_pc_q;
  logic          rsp_err_q;

  logic          accept;
  logic          req_err;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   load_data;

  assign req_ready = (state_q == StIdle) & reset;
  assign accept    = req_valid & req_ready;

  // Classify the request at acceptance; an error skips the memory entirely.
  always_comb begin
    req_err = 1'b0;
    case (req_op)
      OpLw:         req_err = |req_addr[1:0];
      OpLh, OpLhu:  req_err = req_addr[0];
      OpLb, OpLbu:  req_err = 1'b0;
      default:      req_err = 1'b1;
    endcase
    if ({req_addr[31:2], 2'b00} >= ADDR_LIMIT) begin
      req_err = 1'b1;
    end
  end

  // Little-endian lane select on the returned word.
  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (addr_lo_q)
      2'b00:   sel_byte = mem_rdata[7:0];
      2'b01:   sel_byte = mem_rdata[15:8];
      2'b10:   sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_data = 32'h0;
    case (op_q)
      OpLw:    load_data = mem_rdata;
      OpLh:    load_data = {{16{sel_half[15]}}, sel_half};
      OpLhu:   load_data = {16'h0, sel_half};
      OpLb:    load_data = {{24{sel_byte[7]}}, sel_byte};
      OpLbu:   load_data = {24'h0, sel_byte};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = req_err ? StResp : StRead;
        end
      end
      StRead: begin
        state_d = StWait;
        cnt_d   = 2'd0;
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      addr_lo_q  <= 2'd0;
      op_q       <= 3'd0;
      mem_addr_q <= '0;
      rsp_data_q <= 32'h0;
      rsp_pc_q   <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_lo_q  <= req_addr[1:0];
        op_q       <= req_op;
        rsp_pc_q   <= req_pc;
        rsp_err_q  <= req_err;
        rsp_data_q <= 32'h0;
        // Only a real read moves the memory address.
        if (!req_err) begin
          mem_addr_q <= req_addr[AW+1:2];
        end
      end
      // Capture on the last WAIT cycle, exactly RD_LAT cycles after the strobe.
      if ((state_q == StWait) && (cnt_q == CntLast)) begin
        rsp_data_q <= load_data;
      end
    end
  end

  assign mem_rd_en = (state_q == StRead);
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_pc    = rsp_pc_q;

`ifdef DM_LOAD_TRACE_EN
  logic [31:0] trace_addr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      trace_addr_q <= 32'h0;
    end else if (accept) begin
      trace_addr_q <= {req_addr[31:2], 2'b00};
    end
  end

  always @(posedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (rsp_err_q) begin
        $display("%d@%h: load error *%h", $time, rsp_pc_q, trace_addr_q);
      end else begin
        $display("%d@%h: %h <= *%h", $time, rsp_pc_q, rsp_data_q, trace_addr_q);
      end
    end
  end
`endif

endmodule
